layer_serializer: RTL and testbench



---
 rtl/nn_pkg.sv | 18 +
 rtl/layer_serializer_if.sv | 37 +++
 rtl/layer_serializer.sv | 98 +++++++++
 tb/tb_layer_serializer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared constants and types for the neural-network datapath.
// Layer sizes here set the defaults of every per-layer block.
package nn_pkg;

   localparam int NN_DATA_WIDTH = 16;
   localparam int NN_INPUTS     = 784;
   localparam int NN_HIDDEN1    = 30;
   localparam int NN_HIDDEN2    = 30;
   localparam int NN_HIDDEN3    = 10;
   localparam int NN_OUTPUTS    = 10;
   localparam int SIGMOID_SIZE  = 5;

   typedef enum logic {
      SER_IDLE,
      SER_SEND
   } ser_state_t;

endpackage

// File: rtl/layer_serializer_if.sv
// Vector-in / word-stream-out bus of layer_serializer.
// master is the serializer's view, slave the view of its neighbours; LAYER_SER_INDEX_EN adds out_index.
interface layer_serializer_if
   import nn_pkg::*;
#(
   parameter int DATA_WIDTH = NN_DATA_WIDTH,
   parameter int NEURONS    = NN_HIDDEN1
) ();

   logic                          in_valid;
   logic [NEURONS*DATA_WIDTH-1:0] in_data;
   logic                          in_ready;
   logic                          out_valid;
   logic [DATA_WIDTH-1:0]         out_data;
   logic                          out_last;
   logic                          out_ready;
`ifdef LAYER_SER_INDEX_EN
   logic [$clog2(NEURONS)-1:0]    out_index;
`endif

   modport master (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
`ifdef LAYER_SER_INDEX_EN
      , output out_index
`endif
   );

   modport slave (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
`ifdef LAYER_SER_INDEX_EN
      , input out_index
`endif
   );

endinterface

// File: rtl/layer_serializer.sv
// Streams a captured layer vector word by word (neuron 0 first) with a shadow buffer for back-to-back vectors.
// Optional macro LAYER_SER_INDEX_EN exports the element index as out_index.
module layer_serializer
   import nn_pkg::*;
#(
   parameter int DATA_WIDTH = NN_DATA_WIDTH,
   parameter int NEURONS    = NN_HIDDEN1,
   parameter int IDX_WIDTH  = $clog2(NEURONS)
) (
   input  logic               clk,
   input  logic               rst_n,
   layer_serializer_if.master bus,
   output logic               busy,
   output logic               overrun
);

   ser_state_t            state, state_next;
   logic                  a_vld;
   logic                  s_vld, s_vld_next;
   logic [IDX_WIDTH-1:0]  idx, idx_next;
   logic [DATA_WIDTH-1:0] a_buf [NEURONS];
   logic [DATA_WIDTH-1:0] s_buf [NEURONS];
   logic                  beat, last_beat, capture;
   logic                  load_a_in, load_a_s, load_s;

   assign a_vld     = (state == SER_SEND);
   assign beat      = a_vld && bus.out_ready;
   assign last_beat = beat && (idx == IDX_WIDTH'(NEURONS - 1));
   assign capture   = bus.in_valid && !s_vld;

   assign bus.in_ready  = !s_vld;
   assign bus.out_valid = a_vld;
   assign bus.out_data  = a_buf[idx];
   assign bus.out_last  = a_vld && (idx == IDX_WIDTH'(NEURONS - 1));
   assign busy          = a_vld || s_vld;
`ifdef LAYER_SER_INDEX_EN
   assign bus.out_index = a_vld ? idx : '0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= SER_IDLE;
         s_vld   <= 1'b0;
         idx     <= '0;
         overrun <= 1'b0;
      end else begin
         state   <= state_next;
         s_vld   <= s_vld_next;
         idx     <= idx_next;
         overrun <= overrun || (bus.in_valid && s_vld);
      end
   end

   // Beat progress first; a capture then overrides A when A is free or just emptied.
   always_comb begin
      state_next = state;
      s_vld_next = s_vld;
      idx_next   = idx;
      load_a_in  = 1'b0;
      load_a_s   = 1'b0;
      load_s     = 1'b0;
      if (last_beat) begin
         idx_next = '0;
         if (s_vld) begin
            load_a_s   = 1'b1;
            s_vld_next = 1'b0;
         end else begin
            state_next = SER_IDLE;
         end
      end else if (beat) begin
         idx_next = idx + IDX_WIDTH'(1);
      end
      if (capture) begin
         if (!a_vld || last_beat) begin
            load_a_in  = 1'b1;
            state_next = SER_SEND;
            idx_next   = '0;
         end else begin
            load_s     = 1'b1;
            s_vld_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (load_a_in) begin
         for (int k = 0; k < NEURONS; k++)
            a_buf[k] <= bus.in_data[k*DATA_WIDTH +: DATA_WIDTH];
      end else if (load_a_s) begin
         a_buf <= s_buf;
      end
      if (load_s) begin
         for (int k = 0; k < NEURONS; k++)
            s_buf[k] <= bus.in_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

endmodule

// File: tb/tb_layer_serializer.sv
// Bench for layer_serializer: directed cycle table, then random traffic against a vector-queue model.
// Build with +define+LAYER_SER_INDEX_EN to also check out_index.
module tb_layer_serializer;

   localparam int DW = 16;
   localparam int N  = 4;

   typedef struct {
      logic          rst_n;
      logic          in_valid;
      logic [N*DW-1:0] in_data;
      logic          out_ready;
      logic          e_out_valid;
      logic [DW-1:0] e_out_data;
      logic          e_out_last;
      logic          e_in_ready;
      logic          e_busy;
      logic          e_overrun;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic busy, overrun;
   int   checks = 0;
   int   failures = 0;

   logic [N*DW-1:0] mq [$];
   int              pos;
   bit              m_ovr;
   vec_t            vecs [$];

   localparam logic [N*DW-1:0] V1 = 64'h0004_0003_0002_0001;
   localparam logic [N*DW-1:0] V2 = 64'h0008_0007_0006_0005;
   localparam logic [N*DW-1:0] V3 = 64'hDEAD_BEEF_CAFE_F00D;

   always #5 clk = ~clk;

   layer_serializer_if #(.DATA_WIDTH(DW), .NEURONS(N)) bus ();

   layer_serializer #(.DATA_WIDTH(DW), .NEURONS(N)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .busy    (busy),
      .overrun (overrun)
   );

   function automatic vec_t mk(logic r, logic iv, logic [N*DW-1:0] d, logic ordy,
                               logic eov, logic [DW-1:0] ed, logic el, logic eir,
                               logic eb, logic eovr);
      vec_t v;
      v.rst_n = r; v.in_valid = iv; v.in_data = d; v.out_ready = ordy;
      v.e_out_valid = eov; v.e_out_data = ed; v.e_out_last = el;
      v.e_in_ready = eir; v.e_busy = eb; v.e_overrun = eovr;
      return v;
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drives one cycle, advances the model across the edge, and leaves time at edge+1.
   task automatic apply_stimulus(input logic r, input logic iv, input logic [N*DW-1:0] d, input logic ordy);
      bit beat, cap, ovr_set;
      rst_n         = r;
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.out_ready = ordy;
      beat    = (mq.size() > 0) && ordy;
      cap     = iv && (mq.size() < 2);
      ovr_set = iv && (mq.size() >= 2);
      @(posedge clk);
      if (!r) begin
         mq.delete();
         pos   = 0;
         m_ovr = 0;
      end else begin
         if (beat) begin
            pos++;
            if (pos == N) begin
               void'(mq.pop_front());
               pos = 0;
            end
         end
         if (cap) mq.push_back(d);
         if (ovr_set) m_ovr = 1;
      end
      #1;
   endtask

   task automatic check_model();
      logic [N*DW-1:0] front;
      bit              have;
      have = (mq.size() > 0);
      front = have ? mq[0] : '0;
      check_output("m_out_valid", 32'(bus.out_valid), 32'(have));
      if (have) begin
         check_output("m_out_data", 32'(bus.out_data), 32'(front[pos*DW +: DW]));
      end
      check_output("m_out_last", 32'(bus.out_last), 32'(have && pos == N-1));
      check_output("m_in_ready", 32'(bus.in_ready), 32'(mq.size() < 2));
      check_output("m_busy", 32'(busy), 32'(have));
      check_output("m_overrun", 32'(overrun), 32'(m_ovr));
`ifdef LAYER_SER_INDEX_EN
      check_output("m_out_index", 32'(bus.out_index), have ? 32'(pos) : 32'd0);
`endif
   endtask

   initial begin
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.out_ready = 1'b0;
      pos = 0;
      m_ovr = 0;

      // reset, single vector
      vecs.push_back(mk(0,0,0 ,0, 0,16'h0,0,1,0,0));
      vecs.push_back(mk(1,1,V1,1, 1,16'h1,0,1,1,0));
      vecs.push_back(mk(1,0,0 ,1, 1,16'h2,0,1,1,0));
      vecs.push_back(mk(1,0,0 ,1, 1,16'h3,0,1,1,0));
      vecs.push_back(mk(1,0,0 ,1, 1,16'h4,1,1,1,0));
      vecs.push_back(mk(1,0,0 ,1, 0,16'h0,0,1,0,0));
      // backpressure 1,0,0,1,...
      vecs.push_back(mk(1,1,V1,0, 1,16'h1,0,1,1,0));
      vecs.push_back(mk(1,0,0 ,1, 1,16'h2,0,1,1,0));
      vecs.push_back(mk(1,0,0 ,0, 1,16'h2,0,1,1,0));
      vecs.push_back(mk(1,0,0 ,0, 1,16'h2,0,1,1,0));
      vecs.push_back(mk(1,0,0 ,1, 1,16'h3,0,1,1,0));
      vecs.push_back(mk(1,0,0 ,1, 1,16'h4,1,1,1,0));
      vecs.push_back(mk(1,0,0 ,0, 1,16'h4,1,1,1,0));
      vecs.push_back(mk(1,0,0 ,0, 1,16'h4,1,1,1,0));
      vecs.push_back(mk(1,0,0 ,1, 0,16'h0,0,1,0,0));
      // back-to-back, V2 during beat 2 of V1
      vecs.push_back(mk(1,1,V1,1, 1,16'h1,0,1,1,0));
      vecs.push_back(mk(1,0,0 ,1, 1,16'h2,0,1,1,0));
      vecs.push_back(mk(1,1,V2,1, 1,16'h3,0,0,1,0));
      vecs.push_back(mk(1,0,0 ,1, 1,16'h4,1,0,1,0));
      vecs.push_back(mk(1,0,0 ,1, 1,16'h5,0,1,1,0));
      vecs.push_back(mk(1,0,0 ,1, 1,16'h6,0,1,1,0));
      vecs.push_back(mk(1,0,0 ,1, 1,16'h7,0,1,1,0));
      vecs.push_back(mk(1,0,0 ,1, 1,16'h8,1,1,1,0));
      vecs.push_back(mk(1,0,0 ,1, 0,16'h0,0,1,0,0));
      // overrun: V3 dropped while shadow full
      vecs.push_back(mk(1,1,V1,0, 1,16'h1,0,1,1,0));
      vecs.push_back(mk(1,1,V2,0, 1,16'h1,0,0,1,0));
      vecs.push_back(mk(1,1,V3,0, 1,16'h1,0,0,1,1));
      vecs.push_back(mk(1,0,0 ,1, 1,16'h2,0,0,1,1));
      vecs.push_back(mk(1,0,0 ,1, 1,16'h3,0,0,1,1));
      vecs.push_back(mk(1,0,0 ,1, 1,16'h4,1,0,1,1));
      vecs.push_back(mk(1,0,0 ,1, 1,16'h5,0,1,1,1));
      vecs.push_back(mk(1,0,0 ,1, 1,16'h6,0,1,1,1));
      vecs.push_back(mk(1,0,0 ,1, 1,16'h7,0,1,1,1));
      vecs.push_back(mk(1,0,0 ,1, 1,16'h8,1,1,1,1));
      vecs.push_back(mk(1,0,0 ,1, 0,16'h0,0,1,0,1));
      vecs.push_back(mk(1,0,0 ,1, 0,16'h0,0,1,0,1));
      // reset mid-send after beat 2, then a fresh vector
      vecs.push_back(mk(0,0,0 ,0, 0,16'h0,0,1,0,0));
      vecs.push_back(mk(1,1,V1,1, 1,16'h1,0,1,1,0));
      vecs.push_back(mk(1,0,0 ,1, 1,16'h2,0,1,1,0));
      vecs.push_back(mk(1,0,0 ,1, 1,16'h3,0,1,1,0));
      vecs.push_back(mk(0,0,0 ,1, 0,16'h0,0,1,0,0));
      vecs.push_back(mk(1,0,0 ,1, 0,16'h0,0,1,0,0));
      vecs.push_back(mk(1,1,V2,1, 1,16'h5,0,1,1,0));
      vecs.push_back(mk(1,0,0 ,1, 1,16'h6,0,1,1,0));
      vecs.push_back(mk(1,0,0 ,1, 1,16'h7,0,1,1,0));
      vecs.push_back(mk(1,0,0 ,1, 1,16'h8,1,1,1,0));
      vecs.push_back(mk(1,0,0 ,1, 0,16'h0,0,1,0,0));

      #2;
      foreach (vecs[i]) begin
         apply_stimulus(vecs[i].rst_n, vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready);
         check_output("t_out_valid", 32'(bus.out_valid), 32'(vecs[i].e_out_valid));
         if (vecs[i].e_out_valid)
            check_output("t_out_data", 32'(bus.out_data), 32'(vecs[i].e_out_data));
         check_output("t_out_last", 32'(bus.out_last), 32'(vecs[i].e_out_last));
         check_output("t_in_ready", 32'(bus.in_ready), 32'(vecs[i].e_in_ready));
         check_output("t_busy", 32'(busy), 32'(vecs[i].e_busy));
         check_output("t_overrun", 32'(overrun), 32'(vecs[i].e_overrun));
         check_model();
      end

      // random traffic; occasional resets clear the sticky overrun
      for (int c = 0; c < 3000; c++) begin
         logic r, iv, ordy;
         logic [N*DW-1:0] d;
         r    = ($urandom_range(0, 299) != 0);
         iv   = ($urandom_range(0, 3) == 0);
         ordy = ($urandom_range(0, 2) != 0);
         d    = {$urandom(), $urandom()};
         apply_stimulus(r, iv, d, ordy);
         check_model();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
